signed_pow2_divider_pipe: RTL and testbench
===========================================

// Module: signed_pow2_divider_pipe
// PURPOSE
//  Pipelined signed divide of an N-bit two's-complement operand by 2**shift, with the shift amount chosen at run time.
//  Successor to the fixed-S arithmetic-shift blocks: runtime shift, two rounding modes, valid/ready handshake, 2-stage pipe.
//  Sits between a producer and consumer stream; throughput 1 op/clk when unstalled.
// PARAMETERS
//  N    8              operand/result width, N >= 2
//  SW   $clog2(N)      localparam, shift-amount width (legal shift 0..N-1)
// PORTS
//  clk        in   1   single clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   input operand valid
//  in_ready   out  1   block can accept input this cycle
//  in_data    in   N   signed dividend
//  in_shift   in   SW  exponent s, divisor = 2**s
//  in_mode    in   1   0 = FLOOR (same as >>>), 1 = TRUNC (toward zero, same as signed '/')
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  out_data   out  N   signed quotient
//  out_rem    out  N   signed remainder (only with DIV_POW2_REMAINDER_EN)
// BEHAVIOUR
//  - Transfer occurs on posedge when valid && ready on that interface; data unchanged while valid && !ready.
//  - Stage 1 (S1): registers a, s, mode, and bias = (mode==TRUNC && a[N-1]) ? (2**s - 1) : 0.
//  - Stage 2 (S2): registers q = (a + bias) >>> s, evaluated in N+1 bits with sign extension, then truncated to N bits (no overflow possible).
//  - Latency: input accepted in cycle t -> out_valid high in cycle t+2 when out_ready stayed high.
//  - Ready chain: s2_ready = !s2_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready (combinational, no skid buffer).
//    Bubbles are collapsed; a full pipe with out_ready low holds both stages and drives in_ready=0.
//  - Simultaneous accept-in and drain-out in one cycle is legal: no throughput loss.
//  - rst: s1_valid, s2_valid, out_valid = 0; data registers cleared to 0; out_data = 0, out_rem = 0.
//    in_ready is 1 in the first cycle after reset.
//  - Reset mid-operation: in-flight ops are dropped, not completed; no output pulse after reset.
//  - Boundaries:
//    s=0: q = a (both modes), rem = 0.
//    a = -2**(N-1), s = N-1: q = -1 (both modes).
//    a = -1, s > 0: FLOOR gives -1, TRUNC gives 0.
//    Positive a: both modes identical.
//  - Inputs are not sampled when in_valid=0; in_shift/in_mode are captured per op (may change every op).
// CONFIGURATION
//  DIV_POW2_REMAINDER_EN defined:
//   - out_rem port present; S2 registers rem = a - (q << s), in N bits.
//   - FLOOR: rem in [0, 2**s - 1]. TRUNC: rem has the sign of a, or is 0.
//  DIV_POW2_REMAINDER_EN undefined:
//   - out_rem port and its registers absent; all other behaviour identical.
// STRUCTURE
//  - Package div_pow2_pkg:
//    typedef enum logic {DIV_FLOOR = 1'b0, DIV_TRUNC = 1'b1} div_mode_t;
//    function bias_for(a, s, mode).
//  - Sub-module div_pow2_pipe_stage #(W): generic valid/ready register slice (valid, data, ready rule above).
//    Instantiated twice, payload widths differ.
//  - Top holds only the arithmetic between the slices.
// TESTING (N=8)
//  1. a=-13 (F3), s=2, FLOOR -> q=-4 (FC), rem=3. Same op with TRUNC -> q=-3 (FD), rem=-1 (FF).
//  2. a=-128 (80), s=7, both modes -> q=-1 (FF). a=-1, s=3 -> FLOOR FF, TRUNC 00. s=0, any a -> q=a, rem=0.
//  3. Stream of 16 random ops with out_ready=1: results in order, exactly 2-cycle latency, in_ready constant 1.
//     Results checked against a/2**s (TRUNC) and a>>>s (FLOOR).
//  4. Backpressure: fill pipe, hold out_ready=0 for 5 clks -> in_ready=0 after 2 accepts, out_data stable.
//     Release -> no loss or duplication.
//  5. Assert rst with 2 ops in flight -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result emerges.
//  6. Alternate in_valid 1/0 with random out_ready -> bubbles collapse; the output sequence equals the input sequence order.

Source files
------------

// File: rtl/div_pow2_pkg.sv
// Shared types and helpers for the signed power-of-two divider pipeline.
// Optional remainder output: DIV_POW2_REMAINDER_EN.
package div_pow2_pkg;

    typedef enum logic {
        DIV_FLOOR = 1'b0,
        DIV_TRUNC = 1'b1
    } div_mode_t;

    localparam int unsigned BIAS_W = 32;

    // Truncation toward zero adds 2**s - 1 to negative dividends before the shift.
    function automatic logic [BIAS_W-1:0] bias_for(
        input logic        a_neg,
        input int unsigned s,
        input div_mode_t   mode
    );
        if (mode == DIV_TRUNC && a_neg) begin
            return (32'd1 << s) - 32'd1;
        end
        return '0;
    endfunction

endpackage

// File: rtl/div_pow2_pipe_stage.sv
// Generic valid/ready register slice; ready passes through combinationally.
// Used twice by the divider with different payload widths.
module div_pow2_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/signed_pow2_divider_pipe.sv
// Two-stage pipelined signed divide by 2**shift, FLOOR or TRUNC rounding.
// Define DIV_POW2_REMAINDER_EN to add the out_rem port and its registers.
module signed_pow2_divider_pipe
    import div_pow2_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shift,
    input  logic          in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
`ifdef DIV_POW2_REMAINDER_EN
    ,
    output logic [N-1:0]  out_rem
`endif
);

    localparam int P1 = 2 * N + SW + 1;
`ifdef DIV_POW2_REMAINDER_EN
    localparam int P2 = 2 * N;
`else
    localparam int P2 = N;
`endif

    logic [BIAS_W-1:0] bias_full;
    logic [N-1:0]      bias_in;
    logic [P1-1:0]     s1_in;
    logic [P1-1:0]     s1_out;
    logic              s1_valid;
    logic              s2_ready;

    assign bias_full = bias_for(in_data[N-1], int'(in_shift), div_mode_t'(in_mode));
    assign bias_in   = bias_full[N-1:0];
    assign s1_in     = {in_data, in_shift, in_mode, bias_in};

    div_pow2_pipe_stage #(.W(P1)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    logic [N-1:0]      s1_a;
    logic [SW-1:0]     s1_s;
    logic              s1_m;
    logic [N-1:0]      s1_bias;
    logic [N-1:0]      bias_eff;
    logic signed [N:0] sum;
    logic [N-1:0]      q_c;

    assign {s1_a, s1_s, s1_m, s1_bias} = s1_out;
    assign bias_eff = (div_mode_t'(s1_m) == DIV_TRUNC) ? s1_bias : '0;

    // One extra bit keeps a + bias from wrapping before the arithmetic shift.
    assign sum = $signed({s1_a[N-1], s1_a}) + $signed({1'b0, bias_eff});
    assign q_c = N'(sum >>> s1_s);

    logic [P2-1:0] s2_in;
    logic [P2-1:0] s2_out;

`ifdef DIV_POW2_REMAINDER_EN
    logic [N-1:0] rem_c;
    assign rem_c = s1_a - (q_c << s1_s);
    assign s2_in = {q_c, rem_c};
`else
    assign s2_in = q_c;
`endif

    div_pow2_pipe_stage #(.W(P2)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

`ifdef DIV_POW2_REMAINDER_EN
    assign out_data = s2_out[P2-1:N];
    assign out_rem  = s2_out[N-1:0];
`else
    assign out_data = s2_out;
`endif

endmodule

// File: tb/tb_signed_pow2_divider_pipe.sv
// Directed-vector and scoreboard bench for signed_pow2_divider_pipe (N=8).
// Checks out_rem as well when DIV_POW2_REMAINDER_EN is defined.
module tb_signed_pow2_divider_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shift;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef DIV_POW2_REMAINDER_EN
    logic [7:0] out_rem;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [2:0] s;
        logic       m;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[12];

    always #5 clk = ~clk;

    signed_pow2_divider_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DIV_POW2_REMAINDER_EN
        ,
        .out_rem   (out_rem)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h need=%h", nm, act, req);
        end
    endtask

    function automatic void model(input logic [7:0] a, input logic [2:0] s, input logic m,
                                  output logic [7:0] q, output logic [7:0] r);
        int ai, qi, d;
        ai = int'($signed(a));
        d  = 1 << s;
        if (m) qi = ai / d;
        else   qi = ai >>> s;
        q = 8'(qi);
        r = 8'(ai - qi * d);
    endfunction

    // Drive one cycle, then score both handshakes that occur on the coming edge.
    task automatic tick(input logic iv, input logic [7:0] a, input logic [2:0] s,
                        input logic m, input logic ordy,
                        input logic [7:0] eq, input logic [7:0] er);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = a;
        in_shift  = s;
        in_mode   = m;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%h need=none", out_data);
            end else begin
                e = sbq.pop_front();
                chk("q", {24'd0, out_data}, {24'd0, e.q});
`ifdef DIV_POW2_REMAINDER_EN
                chk("rem", {24'd0, out_rem}, {24'd0, e.r});
`endif
            end
        end
        if (in_valid && in_ready) sbq.push_back('{q: eq, r: er});
    endtask

    task automatic rop(input logic iv, input logic ordy);
        logic [7:0] a, q, r;
        logic [2:0] s;
        logic       m;
        a = 8'($urandom);
        s = 3'($urandom_range(0, 7));
        m = 1'($urandom_range(0, 1));
        model(a, s, m, q, r);
        tick(iv, a, s, m, ordy, q, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            tick(1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0);
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d need=0 pending", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        logic [7:0] cq, cr;
        vt[0]  = '{8'hF3, 3'd2, 1'b0, 8'hFC, 8'h03};
        vt[1]  = '{8'hF3, 3'd2, 1'b1, 8'hFD, 8'hFF};
        vt[2]  = '{8'h80, 3'd7, 1'b0, 8'hFF, 8'h00};
        vt[3]  = '{8'h80, 3'd7, 1'b1, 8'hFF, 8'h00};
        vt[4]  = '{8'hFF, 3'd3, 1'b0, 8'hFF, 8'h07};
        vt[5]  = '{8'hFF, 3'd3, 1'b1, 8'h00, 8'hFF};
        vt[6]  = '{8'h5A, 3'd0, 1'b0, 8'h5A, 8'h00};
        vt[7]  = '{8'hA5, 3'd0, 1'b1, 8'hA5, 8'h00};
        vt[8]  = '{8'h7F, 3'd3, 1'b0, 8'h0F, 8'h07};
        vt[9]  = '{8'h7F, 3'd3, 1'b1, 8'h0F, 8'h07};
        vt[10] = '{8'h81, 3'd1, 1'b1, 8'hC1, 8'hFF};
        vt[11] = '{8'h81, 3'd1, 1'b0, 8'hC0, 8'h01};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_shift = '0;
        in_mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Directed boundary vectors, one at a time.
        foreach (vt[i]) begin
            tick(1'b1, vt[i].a, vt[i].s, vt[i].m, 1'b1, vt[i].q, vt[i].r);
            drain();
        end

        // Back-to-back stream: first result two samples after first op.
        for (int c = 0; c < 18; c++) begin
            if (c < 16) rop(1'b1, 1'b1);
            else tick(1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0);
            chk("lat_valid", {31'd0, out_valid}, {31'd0, c >= 2});
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drain();

        // Backpressure: two accepts fill the pipe, then it must hold.
        rop(1'b1, 1'b0);
        rop(1'b1, 1'b0);
        model(8'h9C, 3'd2, 1'b1, cq, cr);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 8'h9C, 3'd2, 1'b1, 1'b0, cq, cr);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", {24'd0, out_data}, {24'd0, sbq[0].q});
        end
        tick(1'b1, 8'h9C, 3'd2, 1'b1, 1'b1, cq, cr);
        drain();

        // Reset with two ops in flight.
        rop(1'b1, 1'b1);
        rop(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 8'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0);
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

        // Alternating input with random backpressure.
        for (int k = 0; k < 40; k++) begin
            rop(1'(k % 2 == 0), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog");
    end

endmodule
